// File: rtl/sd_spi_phy.sv
// ----------------------------------------------------------------------------
// sd_spi_phy
//   SD-card SPI physical layer. Runs byte-wide SPI mode-0 transfers (MSB
//   first) at a fast or slow SCK rate, owns the card chip-select register,
//   and debounces the mechanical card-detect switch.
//
// Ports
//   clk28, rst_n          : 28 MHz clock, asynchronous active-low reset
//   start, tx_data, slow  : transfer request; tx_data/slow sampled on accept
//   rx_data, busy, done   : received byte, transfer-in-progress, end pulse
//   cs_we, cs_val         : chip-select write strobe and new level
//   cd_ack                : clears the sticky card_changed flag
//   sd_cs, sd_sck, sd_mosi, sd_miso : card SPI pins
//   sd_cd_n               : raw card-detect switch (low = inserted, async)
//   sd_cd, card_changed   : debounced presence and sticky change flag
// ----------------------------------------------------------------------------
module sd_spi_phy #(
   parameter int SLOW_HALF = 35,
   parameter int FAST_HALF = 2,
   parameter int DEB_BITS  = 16
) (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       slow,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       done,
   input  logic       cs_we,
   input  logic       cs_val,
   input  logic       cd_ack,
   output logic       sd_cs,
   output logic       sd_sck,
   output logic       sd_mosi,
   input  logic       sd_miso,
   input  logic       sd_cd_n,
   output logic       sd_cd,
   output logic       card_changed
);

   localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int CNT_W    = $clog2(HALF_MAX + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   logic [1:0]          state;
   logic [CNT_W-1:0]    half_cnt;
   logic [CNT_W-1:0]    half_lim;
   logic [2:0]          bit_cnt;
   logic [7:0]          shreg;
   logic                half_end;
   logic                accept;

   assign half_end = (half_cnt == (half_lim - CNT_W'(1)));
   assign accept   = (state == ST_IDLE) && start;
   assign busy     = (state != ST_IDLE);

   // Transfer FSM: SCK phases of half_lim cycles each, MOSI updated on the
   // falling edge (or at accept for the first bit).
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         half_cnt <= '0;
         half_lim <= CNT_W'(FAST_HALF);
         bit_cnt  <= '0;
         sd_sck   <= 1'b0;
         sd_mosi  <= 1'b1;
         rx_data  <= 8'hFF;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  half_lim <= slow ? CNT_W'(SLOW_HALF) : CNT_W'(FAST_HALF);
                  half_cnt <= '0;
                  bit_cnt  <= '0;
                  sd_mosi  <= tx_data[7];
                  state    <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (half_end) begin
                  half_cnt <= '0;
                  sd_sck   <= 1'b1;
                  state    <= ST_HIGH;
               end else begin
                  half_cnt <= half_cnt + CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (half_end) begin
                  half_cnt <= '0;
                  sd_sck   <= 1'b0;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data <= shreg;
                     done    <= 1'b1;
                     sd_mosi <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     // shreg was already shifted on the rising edge, so bit 7
                     // now holds the next outgoing bit.
                     sd_mosi <= shreg[7];
                     state   <= ST_LOW;
                  end
               end else begin
                  half_cnt <= half_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Shift register is pure data: loaded on accept, and on each SCK rise the
   // sent MSB leaves while the sampled MISO bit enters at the LSB.
   always_ff @(posedge clk28) begin
      if (accept)
         shreg <= tx_data;
      else if ((state == ST_LOW) && half_end)
         shreg <= {shreg[6:0], sd_miso};
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n)
         sd_cs <= 1'b1;
      else if (cs_we)
         sd_cs <= cs_val;
   end

   // Card detect: 2-flop synchroniser, then a counter that only runs while
   // the synchronised presence disagrees with sd_cd.
   logic                cd_s1;
   logic                cd_s2;
   logic [DEB_BITS-1:0] deb_cnt;
   logic                cd_pending;
   logic                cd_flip;

   assign cd_pending = (~cd_s2) != sd_cd;
   assign cd_flip    = cd_pending && (&deb_cnt);

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         cd_s1        <= 1'b1;
         cd_s2        <= 1'b1;
         deb_cnt      <= '0;
         sd_cd        <= 1'b0;
         card_changed <= 1'b0;
      end else begin
         cd_s1 <= sd_cd_n;
         cd_s2 <= cd_s1;
         if (!cd_pending || cd_flip)
            deb_cnt <= '0;
         else
            deb_cnt <= deb_cnt + DEB_BITS'(1);
         if (cd_flip)
            sd_cd <= ~cd_s2;
         // A new edge takes priority over an acknowledge in the same cycle.
         if (cd_flip)
            card_changed <= 1'b1;
         else if (cd_ack)
            card_changed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_spi_phy.sv
// ----------------------------------------------------------------------------
// tb_sd_spi_phy
//   Directed bench for sd_spi_phy. Expected received bytes and completion
//   cycles are queued when a transfer is issued; a monitor pops them on done.
// ----------------------------------------------------------------------------
module tb_sd_spi_phy;

   localparam int SLOW_H = 35;
   localparam int FAST_H = 2;

   logic       clk28;
   logic       rst_n;
   logic       start;
   logic [7:0] tx_data;
   logic       slow;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       cs_we;
   logic       cs_val;
   logic       cd_ack;
   logic       sd_cs;
   logic       sd_sck;
   logic       sd_mosi;
   logic       sd_miso;
   logic       sd_cd_n;
   logic       sd_cd;
   logic       card_changed;

   sd_spi_phy #(
      .SLOW_HALF (SLOW_H),
      .FAST_HALF (FAST_H),
      .DEB_BITS  (4)
   ) dut (
      .clk28        (clk28),
      .rst_n        (rst_n),
      .start        (start),
      .tx_data      (tx_data),
      .slow         (slow),
      .rx_data      (rx_data),
      .busy         (busy),
      .done         (done),
      .cs_we        (cs_we),
      .cs_val       (cs_val),
      .cd_ack       (cd_ack),
      .sd_cs        (sd_cs),
      .sd_sck       (sd_sck),
      .sd_mosi      (sd_mosi),
      .sd_miso      (sd_miso),
      .sd_cd_n      (sd_cd_n),
      .sd_cd        (sd_cd),
      .card_changed (card_changed)
   );

   initial clk28 = 1'b0;
   always #18 clk28 = ~clk28;

   int cyc = 0;
   always @(posedge clk28) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] rx;
      int         at;
   } exp_t;
   exp_t sb[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // MISO model: loopback, or a fixed byte shifted out MSB first
   logic       loopback = 1'b1;
   logic [7:0] miso_byte = 8'h00;
   int         miso_idx = 7;
   assign sd_miso = loopback ? sd_mosi : miso_byte[miso_idx];

   // SCK monitor: counts rises, measures phase lengths, advances MISO model
   int   rises = 0;
   int   rise_cyc = 0;
   int   fall_cyc = 0;
   int   hi_len = 0;
   int   lo_len = 0;
   logic have_fall = 1'b0;
   logic prev_sck = 1'b0;
   initial begin
      forever begin
         @(negedge clk28);
         if (sd_sck && !prev_sck) begin
            rises++;
            if (have_fall) lo_len = cyc - fall_cyc;
            rise_cyc = cyc;
         end
         if (!sd_sck && prev_sck) begin
            hi_len    = cyc - rise_cyc;
            fall_cyc  = cyc;
            have_fall = 1'b1;
            if (busy && miso_idx > 0) miso_idx--;
         end
         prev_sck = sd_sck;
      end
   end

   // Scoreboard monitor
   int done_cnt = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk28);
         if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               e = sb.pop_front();
               check("rx_data", rx_data, e.rx);
               check("done_cycle", cyc, e.at);
            end
         end
      end
   end

   // Assumes it is called between a negedge and the following posedge.
   task automatic issue(input logic [7:0] b, input logic s, input logic [7:0] rx_exp,
                        input logic expect_done, output int e);
      exp_t x;
      tx_data  = b;
      slow     = s;
      start    = 1'b1;
      miso_idx = 7;
      @(posedge clk28);
      #1;
      start = 1'b0;
      e     = cyc;
      if (expect_done) begin
         x.rx = rx_exp;
         x.at = e + 16 * (s ? SLOW_H : FAST_H);
         sb.push_back(x);
      end
   endtask

   task automatic wait_neg_at(input int c);
      @(negedge clk28);
      while (cyc < c) @(negedge clk28);
   endtask

   task automatic wait_done(input int budget, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk28);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, seen, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   e;
      int   e2;
      int   d;
      int   c;
      int   d0;
      logic seen;

      rst_n   = 1'b0;
      start   = 1'b0;
      tx_data = 8'h00;
      slow    = 1'b0;
      cs_we   = 1'b0;
      cs_val  = 1'b1;
      cd_ack  = 1'b0;
      sd_cd_n = 1'b1;
      repeat (3) @(negedge clk28);
      rst_n = 1'b1;
      @(negedge clk28);

      // Reset state
      check("rst_sck", sd_sck, 1'b0);
      check("rst_mosi", sd_mosi, 1'b1);
      check("rst_cs", sd_cs, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rx", rx_data, 8'hFF);
      check("rst_cd", sd_cd, 1'b0);
      check("rst_changed", card_changed, 1'b0);

      // Fast loopback A5
      loopback = 1'b1;
      rises    = 0;
      issue(8'hA5, 1'b0, 8'hA5, 1'b1, e);
      check("fast_busy", busy, 1'b1);
      wait_done(40, "fast_done_seen");
      check("fast_rises", rises, 8);
      check("fast_mosi_idle", sd_mosi, 1'b1);
      check("fast_busy_end", busy, 1'b0);

      // Slow mode, card returns 3C
      @(negedge clk28);
      loopback  = 1'b0;
      miso_byte = 8'h3C;
      issue(8'hFF, 1'b1, 8'h3C, 1'b1, e);
      wait_done(600, "slow_done_seen");
      check("slow_high_len", hi_len, SLOW_H);
      check("slow_low_len", lo_len, SLOW_H);

      // Extra starts and slow toggling mid-transfer are ignored
      @(negedge clk28);
      loopback = 1'b1;
      d0 = done_cnt;
      issue(8'h5A, 1'b0, 8'h5A, 1'b1, e);
      wait_neg_at(e + 4);
      start   = 1'b1;
      tx_data = 8'h00;
      wait_neg_at(e + 5);
      start = 1'b0;
      slow  = 1'b1;
      wait_neg_at(e + 19);
      start = 1'b1;
      wait_neg_at(e + 20);
      start = 1'b0;
      slow  = 1'b0;
      wait_done(40, "ign_done_seen");
      repeat (40) @(negedge clk28);
      check("ign_single_done", done_cnt - d0, 1);

      // Back-to-back: second start accepted in the done cycle
      @(negedge clk28);
      d0 = done_cnt;
      issue(8'hC3, 1'b0, 8'hC3, 1'b1, e);
      wait_done(40, "b2b_first_done");
      d = cyc;
      issue(8'h01, 1'b0, 8'h01, 1'b1, e2);
      check("b2b_accept_cycle", e2, d + 1);
      check("b2b_busy", busy, 1'b1);
      wait_done(40, "b2b_second_done");
      repeat (5) @(negedge clk28);
      check("b2b_two_dones", done_cnt - d0, 2);
      check("b2b_rx_hold", rx_data, 8'h01);

      // Card detect: short glitch ignored
      sd_cd_n = 1'b0;
      repeat (10) @(negedge clk28);
      sd_cd_n = 1'b1;
      repeat (40) @(negedge clk28);
      check("cd_glitch_cd", sd_cd, 1'b0);
      check("cd_glitch_changed", card_changed, 1'b0);

      // Insert and hold
      sd_cd_n = 1'b0;
      c = cyc;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk28);
         if (sd_cd) begin
            seen = 1'b1;
            break;
         end
      end
      check("cd_insert_seen", seen, 1'b1);
      check("cd_latency_ok", ((cyc - c) >= 17) && ((cyc - c) <= 20), 1'b1);
      check("cd_insert_changed", card_changed, 1'b1);
      cd_ack = 1'b1;
      @(negedge clk28);
      cd_ack = 1'b0;
      check("cd_ack_clears", card_changed, 1'b0);

      // Removal edge with acknowledge held across it: set wins
      sd_cd_n = 1'b1;
      cd_ack  = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk28);
         if (!sd_cd) begin
            seen = 1'b1;
            break;
         end
      end
      cd_ack = 1'b0;
      check("cd_remove_seen", seen, 1'b1);
      check("cd_set_wins", card_changed, 1'b1);

      // Chip select write
      cs_we  = 1'b1;
      cs_val = 1'b0;
      @(negedge clk28);
      cs_we = 1'b0;
      check("cs_write", sd_cs, 1'b0);

      // Reset mid-transfer
      issue(8'h81, 1'b0, 8'h00, 1'b0, e);
      wait_neg_at(e + 10);
      check("pre_rst_sck_high", sd_sck, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_sck", sd_sck, 1'b0);
      check("arst_mosi", sd_mosi, 1'b1);
      check("arst_cs", sd_cs, 1'b1);
      check("arst_busy", busy, 1'b0);
      repeat (2) @(negedge clk28);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (60) @(negedge clk28);
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_rx", rx_data, 8'hFF);
      check("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
